// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial link: FSM state encoding and width helper.
package shift_reg_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Counter width for n states; never below one bit so WIDTH=1 still has a register.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = $clog2(n);
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Modulo-WIDTH bit counter: clear has priority, increments wrap at the terminal count.
module piso_bit_cnt
   import shift_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   localparam int unsigned CW   = clog2_min1(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          term
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = term ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign term = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with load/ready handshake and zero-gap reload.
module piso_tx
   import shift_reg_pkg::*;
#(
   parameter int unsigned WIDTH      = 4,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             last
);

   localparam int unsigned CW = clog2_min1(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt;
   logic             term;
   logic             cnt_clr;
   logic             cnt_inc;

   piso_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .cnt  (cnt),
      .term (term)
   );

   // Next-state and datapath control; ready depends on registers only.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      ready   = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && term);
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               shift_d = din;
               cnt_clr = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!term) begin
               shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
               cnt_inc = 1'b1;
            end else if (load) begin
               shift_d = din;
               cnt_clr = 1'b1;
            end else begin
               cnt_clr = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Serial outputs are decoded from registered state only, so they never glitch on inputs.
   always_comb begin
      sout       = IDLE_LEVEL;
      sout_valid = 1'b0;
      last       = 1'b0;
      if (state_q == ST_SHIFT) begin
         sout       = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
         sout_valid = 1'b1;
         last       = (cnt == CW'(WIDTH - 1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: three configurations, directed streams plus random loopback.
module tb_piso_tx;

   localparam int unsigned WV   [3] = '{4, 4, 1};
   localparam bit          MSBV [3] = '{1'b1, 1'b0, 1'b1};

   typedef struct packed {
      logic       b;
      logic       lst;
      logic [3:0] word;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       ld  [3];
   logic [3:0] dn  [3];
   logic       rdy [3];
   logic       so  [3];
   logic       sv  [3];
   logic       lst [3];

   exp_t       exp_q [3][$];
   logic       obs_q [$];
   int         rem      [3];
   int         rx_n     [3];
   logic [3:0] rx_w     [3];
   int         words_ok [3];
   int         tests;
   int         fails;

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
      .clk(clk), .rst(rst), .load(ld[0]), .din(dn[0]),
      .ready(rdy[0]), .sout(so[0]), .sout_valid(sv[0]), .last(lst[0])
   );
   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
      .clk(clk), .rst(rst), .load(ld[1]), .din(dn[1]),
      .ready(rdy[1]), .sout(so[1]), .sout_valid(sv[1]), .last(lst[1])
   );
   piso_tx #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u2 (
      .clk(clk), .rst(rst), .load(ld[2]), .din(dn[2][0:0]),
      .ready(rdy[2]), .sout(so[2]), .sout_valid(sv[2]), .last(lst[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s[dut%0d] t=%0t: got %0h required %0h", name, i, $time, act, req);
      end
   endtask

   // Reference model: a word is accepted when fewer than two of its predecessor's bits remain.
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (ld[i] && rem[i] <= 1) begin
               logic [3:0] wd;
               exp_t e;
               wd = dn[i] & 4'((1 << WV[i]) - 1);
               rem[i] = WV[i];
               for (int k = 0; k < int'(WV[i]); k++) begin
                  e.b    = MSBV[i] ? wd[WV[i] - 1 - k] : wd[k];
                  e.lst  = (k == int'(WV[i]) - 1);
                  e.word = wd;
                  exp_q[i].push_back(e);
               end
            end else if (rem[i] > 0) begin
               rem[i] = rem[i] - 1;
            end
         end
      end
   end

   // Reset discards any word in flight in the model and the receivers.
   always @(posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         rem[i]  = 0;
         rx_n[i] = 0;
         rx_w[i] = '0;
         exp_q[i].delete();
      end
   end

   // Monitor: handshake timing, bit stream, and word reassembly as a receiver would see it.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk("ready", i, 8'(rdy[i]), 8'(rem[i] <= 1));
         chk("sout_valid", i, 8'(sv[i]), 8'(rem[i] != 0));
         if (sv[i]) begin
            if (i == 0) obs_q.push_back(so[0]);
            if (exp_q[i].size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_bit[dut%0d] t=%0t: got sout=%0b required no valid bit", i, $time, so[i]);
            end else begin
               exp_t e;
               e = exp_q[i].pop_front();
               chk("sout", i, 8'(so[i]), 8'(e.b));
               chk("last", i, 8'(lst[i]), 8'(e.lst));
               if (MSBV[i]) rx_w[i] = (rx_w[i] << 1) | 4'(so[i]);
               else         rx_w[i] = rx_w[i] | (4'(so[i]) << rx_n[i]);
               rx_n[i]++;
               if (e.lst) begin
                  chk("rx_word", i, 8'(rx_w[i]), 8'(e.word));
                  words_ok[i]++;
                  rx_n[i] = 0;
                  rx_w[i] = '0;
               end
            end
         end else begin
            chk("idle_sout", i, 8'(so[i]), 8'h00);
            chk("idle_last", i, 8'(lst[i]), 8'h00);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic l, input logic [3:0] d);
      ld[i] = l;
      dn[i] = d;
   endtask

   task automatic cmp_stream(input string name, input logic [15:0] v, input int n);
      logic [15:0] got;
      logic        ok;
      got = '0;
      ok  = (obs_q.size() == n);
      for (int k = 0; k < obs_q.size() && k < 16; k++) begin
         got = (got << 1) | 16'(obs_q[k]);
         if (k < n && obs_q[k] !== v[n-1-k]) ok = 1'b0;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0d bits %b required %0d bits %b", name, obs_q.size(), got, n, v);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      for (int i = 0; i < 3; i++) begin
         drive(i, 1'b0, 4'h0);
         words_ok[i] = 0;
      end
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      tick();

      // single word 1011
      obs_q.delete();
      drive(0, 1'b1, 4'b1011); tick();
      drive(0, 1'b0, 4'h0); repeat (5) tick();
      cmp_stream("single_1011", 16'b1011, 4);

      // back-to-back A then 5 with the second load on A's last bit
      obs_q.delete();
      drive(0, 1'b1, 4'hA); tick();
      drive(0, 1'b0, 4'h0); repeat (3) tick();
      drive(0, 1'b1, 4'h5); tick();
      drive(0, 1'b0, 4'h0); repeat (5) tick();
      cmp_stream("back_to_back", 16'b10100101, 8);

      // load while busy is dropped
      obs_q.delete();
      drive(0, 1'b1, 4'hC); tick();
      drive(0, 1'b1, 4'h3); tick(); tick();
      drive(0, 1'b0, 4'h0); repeat (5) tick();
      cmp_stream("busy_load", 16'b1100, 4);

      // reset mid-word, outputs must change without a clock edge
      drive(0, 1'b1, 4'hF); tick();
      drive(0, 1'b0, 4'h0); tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("rst_ready", 0, 8'(rdy[0]), 8'h01);
      chk("rst_sout", 0, 8'(so[0]), 8'h00);
      chk("rst_valid", 0, 8'(sv[0]), 8'h00);
      chk("rst_last", 0, 8'(lst[0]), 8'h00);
      tick();
      #2 rst = 1'b0;
      @(posedge clk); #1;
      obs_q.delete();
      drive(0, 1'b1, 4'h6); tick();
      drive(0, 1'b0, 4'h0); repeat (5) tick();
      cmp_stream("after_reset", 16'b0110, 4);

      // random traffic on all three configurations
      repeat (300) begin
         for (int i = 0; i < 3; i++) drive(i, 1'($urandom_range(0, 3) != 0), 4'($urandom));
         tick();
      end
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 4'h0);
      repeat (6) tick();
      for (int i = 0; i < 3; i++) begin
         chk("drained", i, 8'(exp_q[i].size()), 8'h00);
         chk("enough_words", i, 8'(words_ok[i] >= 10), 8'h01);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
